// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Round-robin arbiter and transaction sequencer sharing one 8-bit SPI
//   master engine among NREQ requesters. Multi-byte bursts keep ownership
//   (and therefore the slave select) until the byte flagged req_last. A
//   watchdog aborts transfers whose engine handshake stalls and releases
//   owners that abandon a burst.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req/req_data/req_last  per-requester request, byte, end-of-burst flag
//   ack             one-cycle completion pulse to the owner
//   rsp_data/rsp_err received byte / timeout flag, valid with ack
//   gnt, dev_sel    one-hot owner (dev_sel steers the master's ss)
//   m_start/m_data  start pulse and byte to the SPI master
//   m_busy/m_rdata  SPI master busy and received byte
//
// All outputs are registered.
module spi_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   dev_sel,
  output logic              m_start,
  output logic [7:0]        m_data,
  input  logic              m_busy,
  input  logic [7:0]        m_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ARB, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, owner, win_idx, ptr_rel;
  logic            win, last_q, wd_to;
  logic [CW-1:0]   wd;
  logic [NREQ-1:0] req_m, win_oh, own_oh;

  // A requester being acked this cycle still holds its old request; mask it
  // so the same byte is not issued a second time.
  assign req_m   = req & ~ack;
  assign wd_to   = (wd == CW'(TIMEOUT - 1));
  assign win_oh  = NREQ'(1) << win_idx;
  assign own_oh  = NREQ'(1) << owner;
  assign ptr_rel = IW'((int'(owner) + 1) % NREQ);

  // Round-robin search starting at ptr.
  always_comb begin
    int idx;
    idx     = 0;
    win     = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win && req_m[idx]) begin
        win     = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  // State register and watchdog; the watchdog restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == ARB) wd <= '0;
      else                                    wd <= wd + 1'b1;
    end
  end

  // Next-state logic. Engine handshake progress wins over a same-cycle timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:       if (win) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (m_busy) state_nxt = WAIT_DONE;
                 else if (wd_to) state_nxt = ARB;
      WAIT_DONE: if (!m_busy) state_nxt = last_q ? ARB : HOLD;
                 else if (wd_to) state_nxt = ARB;
      HOLD:      if (req_m[owner]) state_nxt = WAIT_BUSY;
                 else if (wd_to) state_nxt = ARB;
      default:   state_nxt = ARB;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      gnt      <= '0;
      dev_sel  <= '0;
      m_start  <= 1'b0;
      m_data   <= '0;
      ptr      <= '0;
      owner    <= '0;
      last_q   <= 1'b0;
    end else begin
      ack     <= '0;
      m_start <= 1'b0;
      case (state)
        ARB: if (win) begin
          gnt     <= win_oh;
          dev_sel <= win_oh;
          owner   <= win_idx;
          m_data  <= req_data[8*int'(win_idx) +: 8];
          last_q  <= req_last[win_idx];
          m_start <= 1'b1;
        end
        WAIT_BUSY: if (!m_busy && wd_to) begin
          ack      <= own_oh;
          rsp_err  <= 1'b1;
          rsp_data <= '0;
          gnt      <= '0;
          dev_sel  <= '0;
          ptr      <= ptr_rel;
        end
        WAIT_DONE: if (!m_busy) begin
          ack      <= own_oh;
          rsp_err  <= 1'b0;
          rsp_data <= m_rdata;
          if (last_q) begin
            gnt     <= '0;
            dev_sel <= '0;
            ptr     <= ptr_rel;
          end
        end else if (wd_to) begin
          ack      <= own_oh;
          rsp_err  <= 1'b1;
          rsp_data <= '0;
          gnt      <= '0;
          dev_sel  <= '0;
          ptr      <= ptr_rel;
        end
        HOLD: if (req_m[owner]) begin
          m_data  <= req_data[8*int'(owner) +: 8];
          last_q  <= req_last[owner];
          m_start <= 1'b1;
        end else if (wd_to) begin
          // Abandoned burst: release silently.
          gnt     <= '0;
          dev_sel <= '0;
          ptr     <= ptr_rel;
        end
        default: ;
      endcase
    end
  end

endmodule
